// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: double-flop synchronises rx_serial, samples each bit at mid-period,
// and reports good bytes (rx_valid) or stop-bit errors (frame_err) as one-cycle strobes.
module uart_rx_sampler #(
   parameter int CLKS_PER_BIT = 434,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_serial,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy,
   output logic [7:0] rx_count
);

   localparam logic [CNT_W-1:0] HalfM1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BitM1  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bitIdx_q, bitIdx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       count_q, count_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             rxMeta_q, rxSync_q;
   logic             rxS;

   // Both sync flops reset high so an idle line never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
      end else begin
         rxMeta_q <= rx_serial;
         rxSync_q <= rxMeta_q;
      end
   end

   assign rxS = rxSync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
         data_q   <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitIdx_d = bitIdx_q;
      shift_d  = shift_q;
      data_d   = data_q;
      count_d  = count_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxS) state_d = START;
         end
         START: begin
            if (cnt_q == HalfM1) begin
               cnt_d = '0;
               if (!rxS) begin
                  state_d  = DATA;
                  bitIdx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == BitM1) begin
               cnt_d             = '0;
               shift_d[bitIdx_q] = rxS;
               if (bitIdx_q == 3'd7) state_d = STOP;
               else                  bitIdx_d = bitIdx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            // Leaving at mid-stop-bit leaves half a bit to catch a zero-gap next start.
            if (cnt_q == BitM1) begin
               cnt_d = '0;
               if (rxS) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  count_d = count_q + 8'd1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_HIGH: begin
            cnt_d = '0;
            if (rxS) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign rx_count  = count_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: a serial driver pushes expected bytes to a scoreboard and a
// monitor collects rx_valid strobes; each test task pops and compares them inline.
module tb_uart_rx_sampler;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
   localparam int LAT  = 3 + HALF + 9 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_serial = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;
   logic [7:0] rx_count;

   typedef struct {
      logic [7:0] data;
      logic [7:0] count;
      int         stamp;
   } ev_t;

   ev_t        expQ[$];
   ev_t        obsQ[$];
   int         testsRun = 0;
   int         testsFailed = 0;
   int         cycleCnt = 0;
   int         ferrSeen = 0;
   int         bothHigh = 0;
   logic [7:0] expCount = 8'd0;

   uart_rx_sampler #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_serial(rx_serial),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .busy     (busy),
      .rx_count (rx_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Monitor samples on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         ev_t e;
         e.data  = rx_data;
         e.count = rx_count;
         e.stamp = cycleCnt;
         obsQ.push_back(e);
      end
      if (frame_err === 1'b1) ferrSeen++;
      if (rx_valid === 1'b1 && frame_err === 1'b1) bothHigh++;
   end

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Line is left at the stop-bit level so a low stop can be stretched into a break.
   task automatic sendFrame(input logic [7:0] b, input logic stopBit, input logic expectGood);
      ev_t e;
      rx_serial = 1'b0;
      if (expectGood) begin
         expCount = expCount + 8'd1;
         e.data   = b;
         e.count  = expCount;
         e.stamp  = cycleCnt;
         expQ.push_back(e);
      end
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_serial = b[i];
         tick(CPB);
      end
      rx_serial = stopBit;
      tick(CPB);
   endtask

   task automatic popPair(output ev_t ex, output ev_t ob, output bit ok);
      int w = 0;
      ok = 1'b0;
      while (obsQ.size() == 0 && w < 4 * CPB) begin
         tick(1);
         w++;
      end
      if (obsQ.size() != 0 && expQ.size() != 0) begin
         ex = expQ.pop_front();
         ob = obsQ.pop_front();
         ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      testsRun += 5;
      if (rx_data !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_data got %02h expected 00", rx_data); end
      if (rx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got %b expected 0", rx_valid); end
      if (frame_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ferr got %b expected 0", frame_err); end
      if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
      if (rx_count !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_count got %0d expected 0", rx_count); end
      reset = 1'b0;
      tick(2 * CPB);
   endtask

   task automatic test_single();
      ev_t ex, ob;
      bit  ok;
      int  f0 = ferrSeen;
      sendFrame(8'h1F, 1'b1, 1'b1);
      popPair(ex, ob, ok);
      testsRun++;
      if (!ok) begin testsFailed++; $display("[TB] FAIL single_strobe got none expected one rx_valid"); end
      else begin
         testsRun += 3;
         if (ob.data !== 8'h1F) begin testsFailed++; $display("[TB] FAIL single_data got %02h expected 1F", ob.data); end
         if (ob.count !== ex.count) begin testsFailed++; $display("[TB] FAIL single_count got %0d expected %0d", ob.count, ex.count); end
         if (ob.stamp - ex.stamp < LAT - 1 || ob.stamp - ex.stamp > LAT + 1) begin
            testsFailed++; $display("[TB] FAIL single_latency got %0d expected %0d", ob.stamp - ex.stamp, LAT);
         end
      end
      testsRun += 3;
      if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_busy got %b expected 0", busy); end
      if (ferrSeen != f0) begin testsFailed++; $display("[TB] FAIL single_ferr got %0d expected %0d", ferrSeen, f0); end
      if (obsQ.size() != 0) begin testsFailed++; $display("[TB] FAIL single_extra got %0d expected 0", obsQ.size()); end
   endtask

   task automatic test_spaced();
      ev_t        ex, ob;
      bit         ok;
      logic [7:0] bytes[2] = '{8'hA5, 8'hBD};
      for (int i = 0; i < 2; i++) begin
         tick(100 * CPB);
         sendFrame(bytes[i], 1'b1, 1'b1);
         popPair(ex, ob, ok);
         testsRun++;
         if (!ok) begin testsFailed++; $display("[TB] FAIL spaced_strobe%0d got none expected one", i); end
         else begin
            testsRun += 3;
            if (ob.data !== ex.data) begin testsFailed++; $display("[TB] FAIL spaced_data%0d got %02h expected %02h", i, ob.data, ex.data); end
            if (ob.count !== ex.count) begin testsFailed++; $display("[TB] FAIL spaced_count%0d got %0d expected %0d", i, ob.count, ex.count); end
            if (ob.stamp - ex.stamp < LAT - 1 || ob.stamp - ex.stamp > LAT + 1) begin
               testsFailed++; $display("[TB] FAIL spaced_latency%0d got %0d expected %0d", i, ob.stamp - ex.stamp, LAT);
            end
         end
      end
      testsRun++;
      if (rx_count !== 8'd3) begin testsFailed++; $display("[TB] FAIL spaced_total got %0d expected 3", rx_count); end
   endtask

   task automatic test_back_to_back();
      ev_t ex, ob;
      bit  ok;
      sendFrame(8'hBD, 1'b1, 1'b1);
      tick(CPB);
      sendFrame(8'hBD, 1'b1, 1'b1);
      sendFrame(8'h3C, 1'b1, 1'b1);
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         popPair(ex, ob, ok);
         testsRun++;
         if (!ok) begin testsFailed++; $display("[TB] FAIL b2b_strobe%0d got none expected one", i); end
         else begin
            testsRun += 3;
            if (ob.data !== ex.data) begin testsFailed++; $display("[TB] FAIL b2b_data%0d got %02h expected %02h", i, ob.data, ex.data); end
            if (ob.count !== ex.count) begin testsFailed++; $display("[TB] FAIL b2b_count%0d got %0d expected %0d", i, ob.count, ex.count); end
            if (ob.stamp - ex.stamp < LAT - 1 || ob.stamp - ex.stamp > LAT + 1) begin
               testsFailed++; $display("[TB] FAIL b2b_latency%0d got %0d expected %0d", i, ob.stamp - ex.stamp, LAT);
            end
         end
      end
      testsRun++;
      if (rx_count !== 8'd6) begin testsFailed++; $display("[TB] FAIL b2b_total got %0d expected 6", rx_count); end
   endtask

   task automatic test_glitch();
      logic [7:0] c0 = rx_count;
      int         f0 = ferrSeen;
      bit         sawBusy = 1'b0;
      rx_serial = 1'b0;
      tick(HALF / 2);
      rx_serial = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (busy === 1'b1) sawBusy = 1'b1;
      end
      tick(2 * CPB);
      testsRun += 5;
      if (!sawBusy) begin testsFailed++; $display("[TB] FAIL glitch_busy_rise got 0 expected 1"); end
      if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL glitch_busy_fall got %b expected 0", busy); end
      if (obsQ.size() != 0) begin testsFailed++; $display("[TB] FAIL glitch_valid got %0d expected 0", obsQ.size()); end
      if (ferrSeen != f0) begin testsFailed++; $display("[TB] FAIL glitch_ferr got %0d expected %0d", ferrSeen, f0); end
      if (rx_count !== c0) begin testsFailed++; $display("[TB] FAIL glitch_count got %0d expected %0d", rx_count, c0); end
   endtask

   task automatic test_frame_err();
      ev_t        ex, ob;
      bit         ok;
      int         f0 = ferrSeen;
      logic [7:0] d0 = rx_data;
      logic [7:0] c0 = rx_count;
      sendFrame(8'h55, 1'b0, 1'b0);
      tick(20 * CPB);
      rx_serial = 1'b1;
      tick(2 * CPB);
      testsRun += 4;
      if (ferrSeen != f0 + 1) begin testsFailed++; $display("[TB] FAIL ferr_pulses got %0d expected %0d", ferrSeen - f0, 1); end
      if (obsQ.size() != 0) begin testsFailed++; $display("[TB] FAIL ferr_valid got %0d expected 0", obsQ.size()); end
      if (rx_data !== d0) begin testsFailed++; $display("[TB] FAIL ferr_data_held got %02h expected %02h", rx_data, d0); end
      if (rx_count !== c0) begin testsFailed++; $display("[TB] FAIL ferr_count_held got %0d expected %0d", rx_count, c0); end
      sendFrame(8'h12, 1'b1, 1'b1);
      popPair(ex, ob, ok);
      testsRun++;
      if (!ok) begin testsFailed++; $display("[TB] FAIL ferr_recover got none expected one"); end
      else begin
         testsRun += 3;
         if (ob.data !== 8'h12) begin testsFailed++; $display("[TB] FAIL ferr_recover_data got %02h expected 12", ob.data); end
         if (ob.count !== c0 + 8'd1) begin testsFailed++; $display("[TB] FAIL ferr_recover_count got %0d expected %0d", ob.count, c0 + 8'd1); end
         if (ferrSeen != f0 + 1) begin testsFailed++; $display("[TB] FAIL ferr_extra got %0d expected 1", ferrSeen - f0); end
      end
   endtask

   task automatic test_reset_abort();
      ev_t        ex, ob;
      bit         ok;
      int         f0 = ferrSeen;
      logic [7:0] b = 8'h77;
      rx_serial = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_serial = b[i];
         tick(CPB);
      end
      rx_serial = b[4];
      tick(HALF);
      testsRun++;
      if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL abort_busy_before got %b expected 1", busy); end
      reset = 1'b1;
      tick(1);
      testsRun += 3;
      if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_busy got %b expected 0", busy); end
      if (rx_count !== 8'd0) begin testsFailed++; $display("[TB] FAIL abort_count got %0d expected 0", rx_count); end
      if (rx_data !== 8'h00) begin testsFailed++; $display("[TB] FAIL abort_data got %02h expected 00", rx_data); end
      reset = 1'b0;
      rx_serial = 1'b1;
      expCount = 8'd0;
      expQ.delete();
      tick(3 * CPB);
      testsRun += 2;
      if (obsQ.size() != 0) begin testsFailed++; $display("[TB] FAIL abort_valid got %0d expected 0", obsQ.size()); end
      if (ferrSeen != f0) begin testsFailed++; $display("[TB] FAIL abort_ferr got %0d expected %0d", ferrSeen, f0); end
      sendFrame(8'h81, 1'b1, 1'b1);
      popPair(ex, ob, ok);
      testsRun++;
      if (!ok) begin testsFailed++; $display("[TB] FAIL abort_next got none expected one"); end
      else begin
         testsRun += 2;
         if (ob.data !== 8'h81) begin testsFailed++; $display("[TB] FAIL abort_next_data got %02h expected 81", ob.data); end
         if (ob.count !== 8'd1) begin testsFailed++; $display("[TB] FAIL abort_next_count got %0d expected 1", ob.count); end
      end
   endtask

   task automatic test_wrap();
      ev_t        ex, ob;
      bit         ok;
      logic [7:0] b;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      expCount = 8'd0;
      expQ.delete();
      obsQ.delete();
      tick(CPB);
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom_range(0, 255));
         sendFrame(b, 1'b1, 1'b1);
         popPair(ex, ob, ok);
         testsRun++;
         if (!ok) begin testsFailed++; $display("[TB] FAIL wrap_strobe%0d got none expected one", i); end
         else begin
            testsRun += 2;
            if (ob.data !== ex.data) begin testsFailed++; $display("[TB] FAIL wrap_data%0d got %02h expected %02h", i, ob.data, ex.data); end
            if (ob.count !== ex.count) begin testsFailed++; $display("[TB] FAIL wrap_count%0d got %0d expected %0d", i, ob.count, ex.count); end
         end
      end
      testsRun++;
      if (rx_count !== 8'd0) begin testsFailed++; $display("[TB] FAIL wrap_final got %0d expected 0", rx_count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_spaced();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_abort();
      test_wrap();
      testsRun++;
      if (bothHigh != 0) begin testsFailed++; $display("[TB] FAIL exclusive_strobes got %0d overlaps expected 0", bothHigh); end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
